// File: rtl/nibble_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_link_pkg
// Brief    : Shared constants and state encodings for the 4-bit nibble link.
// Revision : 1.0
// ============================================================================
package nibble_link_pkg;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 8;
    localparam int IDX_W   = $clog2(NUM_NIB);
    localparam int CNT_W   = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] DRIVE = 2'b01;
    localparam logic [1:0] GAP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/link_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : link_timeout_ctr
// Brief    : Cycle counter with clear/enable; flags the cycle that completes
//            'limit' enabled cycles since the last clear.
// Revision : 1.0
// ============================================================================
module link_timeout_ctr #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // r_count holds completed cycles, so the limit-th cycle sees limit-1
    assign expire = en && (r_count == limit - CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/nibble_insn_tx.sv
`default_nettype none
// ============================================================================
// Module   : nibble_insn_tx
// Brief    : Sends a 32-bit instruction LSB-nibble-first over a send/ack
//            nibble link, with inter-nibble gap and drive timeout.
// Revision : 1.0
// ============================================================================
module nibble_insn_tx
    import nibble_link_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int GAP_CYC = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic [NIB_W-1:0]  nib_out,
    output logic              send_out,
    input  logic              ack_in,
    output logic [IDX_W-1:0]  nib_idx,
    output logic              busy,
    output logic              done_pulse,
    output logic              timeout_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W / NIB_W - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_shift;
    logic [NIB_W-1:0]  r_nib;
    logic [IDX_W-1:0]  r_idx;
    logic              r_send;
    logic              r_done;
    logic              r_terr;
    logic              r_ready;
    logic              r_busy;

    logic              w_accept;
    logic              w_ack;
    logic              w_last;
    logic              w_abort;
    logic              w_gap_done;
    logic              w_ctr_clear;
    logic              w_ctr_en;
    logic              w_expire;
    logic [CNT_W-1:0]  w_limit;

    assign w_accept   = (r_state == IDLE) && word_valid;
    assign w_ack      = (r_state == DRIVE) && ack_in;
    assign w_last     = (r_idx == LAST_IDX);
    // An ack arriving in the expiry cycle wins over the abort
    assign w_abort    = (r_state == DRIVE) && !ack_in && (TIMEOUT != 0) && w_expire;
    assign w_gap_done = (r_state == GAP) && w_expire;

    // One counter times both the GAP hold and the DRIVE timeout
    assign w_ctr_en    = (r_state != IDLE);
    assign w_ctr_clear = w_accept || w_ack || w_abort || w_gap_done;
    assign w_limit     = (r_state == GAP) ? CNT_W'(GAP_CYC) : CNT_W'(TIMEOUT);

    link_timeout_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_ctr_clear),
        .en     (w_ctr_en),
        .limit  (w_limit),
        .expire (w_expire)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = DRIVE;
            DRIVE: begin
                if (w_ack)        w_state_next = w_last ? IDLE : GAP;
                else if (w_abort) w_state_next = IDLE;
            end
            GAP:     if (w_gap_done) w_state_next = DRIVE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_nib   <= '0;
            r_idx   <= '0;
            r_send  <= 1'b0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == IDLE);
            r_busy  <= (w_state_next != IDLE);
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= word_data >> NIB_W;
                        r_nib   <= word_data[NIB_W-1:0];
                        r_idx   <= '0;
                        r_terr  <= 1'b0;
                        r_send  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (w_ack) begin
                        r_send <= 1'b0;
                        if (w_last) begin
                            r_done <= 1'b1;
                        end else begin
                            // Next nibble is presented while send is low
                            r_idx   <= r_idx + IDX_W'(1);
                            r_nib   <= r_shift[NIB_W-1:0];
                            r_shift <= r_shift >> NIB_W;
                        end
                    end else if (w_abort) begin
                        r_send <= 1'b0;
                        r_terr <= 1'b1;
                    end
                end
                GAP: begin
                    if (w_gap_done) r_send <= 1'b1;
                end
                default: r_send <= 1'b0;
            endcase
        end
    end

    assign word_ready  = r_ready;
    assign busy        = r_busy;
    assign nib_out     = r_nib;
    assign send_out    = r_send;
    assign nib_idx     = r_idx;
    assign done_pulse  = r_done;
    assign timeout_err = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_nibble_insn_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_insn_tx
// Brief    : Self-checking bench for nibble_insn_tx (GAP_CYC=1 and GAP_CYC=3).
// Revision : 1.0
// ============================================================================
module tb_nibble_insn_tx;

    localparam int TMO = 255;
    localparam int GAP1 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        ack_in = 1'b0;
    logic        word_ready, send_out, busy, done_pulse, timeout_err;
    logic [3:0]  nib_out;
    logic [2:0]  nib_idx;

    logic        word_valid3 = 1'b0;
    logic [31:0] word_data3 = '0;
    logic        ack3 = 1'b0;
    logic        word_ready3, send3, busy3, done3, terr3;
    logic [3:0]  nib3;
    logic [2:0]  nib_idx3;

    always #5 clk = ~clk;

    nibble_insn_tx #(.WORD_W(32), .GAP_CYC(GAP1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .nib_out(nib_out), .send_out(send_out), .ack_in(ack_in),
        .nib_idx(nib_idx), .busy(busy), .done_pulse(done_pulse), .timeout_err(timeout_err));

    nibble_insn_tx #(.WORD_W(32), .GAP_CYC(3), .TIMEOUT(TMO)) dut3 (
        .clk(clk), .rst_n(rst_n), .word_valid(word_valid3), .word_data(word_data3),
        .word_ready(word_ready3), .nib_out(nib3), .send_out(send3), .ack_in(ack3),
        .nib_idx(nib_idx3), .busy(busy3), .done_pulse(done3), .timeout_err(terr3));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which word, which nibble, and whether it is on the wire
    bit          m_ready = 1'b1;
    bit          m_send  = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_terr  = 1'b0;
    int          m_n     = 0;
    int          m_cnt   = 0;
    logic [31:0] m_word  = '0;

    task automatic model_reset();
        m_ready = 1'b1; m_send = 1'b0; m_done = 1'b0; m_terr = 1'b0;
        m_n = 0; m_cnt = 0; m_word = '0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (m_ready) begin
            if (word_valid) begin
                m_word = word_data; m_n = 0; m_terr = 1'b0;
                m_ready = 1'b0; m_send = 1'b1; m_cnt = 0;
            end
        end else if (m_send) begin
            if (ack_in) begin
                m_send = 1'b0; m_cnt = 0;
                if (m_n == 7) begin
                    m_ready = 1'b1; m_done = 1'b1;
                end else begin
                    m_n = m_n + 1;
                end
            end else begin
                m_cnt = m_cnt + 1;
                if (TMO != 0 && m_cnt == TMO) begin
                    m_send = 1'b0; m_ready = 1'b1; m_terr = 1'b1;
                end
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == GAP1) begin
                m_send = 1'b1; m_cnt = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_nib();
        return m_word[4*m_n +: 4];
    endfunction

    int cyc = 0;
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) model_reset();
        else        model_step();
    end

    bit   check_en = 1'b0;
    bit   withhold_on = 1'b0;
    int   withhold_idx = 0;
    bit   spurious = 1'b0;
    bit   spur_force = 1'b0;
    int   t0 = 0;
    int   rise_cyc[$];
    int   rise_nib[$];
    int   done_cyc[$];
    int   hi_run = 0, last_hi = 0;
    logic prev_send = 1'b0;
    logic prev3 = 1'b0;
    logic [3:0] prev_nib3 = '0;
    int   lo3 = 0, gap3_checks = 0, done3_cnt = 0;

    always @(negedge clk) begin
        if (check_en) begin
            chk("word_ready", word_ready, m_ready);
            chk("busy", busy, !m_ready);
            chk("send_out", send_out, m_send);
            chk("done_pulse", done_pulse, m_done);
            chk("timeout_err", timeout_err, m_terr);
            chk("nib_idx", nib_idx, m_n[2:0]);
            chk("nib_out", nib_out, exp_nib());
        end
        if (send_out && !prev_send) begin
            rise_cyc.push_back(cyc - t0);
            rise_nib.push_back(int'(nib_out));
        end
        if (done_pulse) done_cyc.push_back(cyc - t0);
        if (send_out) hi_run++;
        else if (prev_send) begin last_hi = hi_run; hi_run = 0; end
        // Responder: ack one cycle after seeing send, single-cycle pulse
        if (!rst_n) ack_in = 1'b0;
        else if (prev_send && send_out && !ack_in && !(withhold_on && int'(nib_idx) == withhold_idx))
            ack_in = 1'b1;
        else if (!send_out && (spur_force || (spurious && $urandom_range(0, 2) == 0)))
            ack_in = 1'b1;
        else ack_in = 1'b0;
        prev_send = send_out;

        if (rst_n && send3 && prev3) chk("nib3_stable", nib3, prev_nib3);
        if (!send3) lo3++;
        else if (!prev3) begin
            if (nib_idx3 != 3'd0) begin chk("gap3_len", lo3, 3); gap3_checks++; end
            lo3 = 0;
        end
        if (done3) done3_cnt++;
        ack3 = rst_n && prev3 && send3 && !ack3;
        prev3 = send3;
        prev_nib3 = nib3;
    end

    task automatic clear_mon();
        rise_cyc.delete(); rise_nib.delete(); done_cyc.delete();
    endtask

    task automatic send_word(input logic [31:0] d);
        int k = 0;
        @(negedge clk);
        while (!word_ready && k < 2000) begin @(negedge clk); k++; end
        chk("ready_wait", word_ready, 1'b1);
        word_valid = 1'b1; word_data = d; t0 = cyc;
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin @(negedge clk); k++; end while (!done_pulse && k < budget);
        chk("done_seen", done_pulse, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1; model_reset(); check_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", word_ready, 1); chk("rst_busy", busy, 0);
        chk("rst_send", send_out, 0);    chk("rst_nib", nib_out, 0);
        chk("rst_idx", nib_idx, 0);      chk("rst_done", done_pulse, 0);
        chk("rst_terr", timeout_err, 0);

        // GAP_CYC=3 instance: three words
        for (int i = 0; i < 3; i++) begin
            int k = 0;
            @(negedge clk);
            while (!word_ready3 && k < 500) begin @(negedge clk); k++; end
            word_valid3 = 1'b1; word_data3 = $urandom;
            @(negedge clk);
            word_valid3 = 1'b0;
        end
        for (int k = 0; k < 500 && done3_cnt < 3; k++) @(negedge clk);
        chk("done3_count", done3_cnt, 3);
        chk("gap3_seen", gap3_checks, 21);
        chk("terr3", terr3, 0);
        chk("busy3", busy3, 0);

        // Single word with hand-computed timing
        clear_mon();
        send_word(32'h1234_5678);
        wait_done(100);
        chk("w1_rises", rise_nib.size(), 8);
        for (int k = 0; k < rise_nib.size() && k < 8; k++) begin
            chk("w1_nib", rise_nib[k], 8 - k);
            chk("w1_rise_cyc", rise_cyc[k], 1 + 3 * k);
        end
        chk("w1_done_n", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("w1_done_cyc", done_cyc[0], 24);

        // Back-to-back words with valid held through the done cycle
        clear_mon();
        @(negedge clk);
        word_valid = 1'b1; word_data = 32'hFFFF_FFFF; t0 = cyc;
        @(negedge clk);
        word_data = 32'h0000_0000;
        for (int k = 0; k < 100 && !done_pulse; k++) @(negedge clk);
        @(negedge clk);
        word_valid = 1'b0;
        wait_done(100);
        chk("b2b_rises", rise_nib.size(), 16);
        for (int k = 0; k < rise_nib.size() && k < 16; k++)
            chk("b2b_nib", rise_nib[k], (k < 8) ? 15 : 0);
        chk("b2b_done_n", done_cyc.size(), 2);
        if (done_cyc.size() == 2) begin
            chk("b2b_done0", done_cyc[0], 24);
            chk("b2b_done1", done_cyc[1], 48);
        end
        if (rise_cyc.size() == 16) chk("b2b_restart", rise_cyc[8], 25);

        // Spurious ack while idle
        spur_force = 1'b1;
        repeat (3) @(negedge clk);
        spur_force = 1'b0;
        @(negedge clk);
        chk("spur_ready", word_ready, 1);
        chk("spur_idx", nib_idx, 7);
        chk("spur_send", send_out, 0);

        // Random words, random idle gaps, spurious acks in IDLE/GAP
        spurious = 1'b1;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word($urandom);
        end
        wait_done(100);
        spurious = 1'b0;

        // Timeout on nibble 3
        clear_mon();
        withhold_idx = 3; withhold_on = 1'b1;
        send_word($urandom);
        for (int k = 0; k < 400 && !timeout_err; k++) @(negedge clk);
        chk("tmo_terr", timeout_err, 1);
        chk("tmo_send", send_out, 0);
        chk("tmo_ready", word_ready, 1);
        @(negedge clk);
        withhold_on = 1'b0;
        chk("tmo_hi_run", last_hi, TMO);
        chk("tmo_rises", rise_nib.size(), 4);
        chk("tmo_no_done", done_cyc.size(), 0);
        send_word(32'hDEAD_BEEF);
        chk("tmo_cleared", timeout_err, 0);
        wait_done(100);

        // Asynchronous reset in the middle of nibble 5
        send_word($urandom);
        for (int k = 0; k < 100 && !(send_out && nib_idx == 3'd5); k++) @(negedge clk);
        chk("rst_mid_seen", nib_idx, 5);
        check_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_send", send_out, 0);
        chk("async_idx", nib_idx, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; model_reset(); check_en = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", word_ready, 1);
        clear_mon();
        send_word(32'hA5A5_A5A5);
        wait_done(100);
        chk("a5_rises", rise_nib.size(), 8);
        for (int k = 0; k < rise_nib.size() && k < 8; k++)
            chk("a5_nib", rise_nib[k], (k % 2 == 0) ? 5 : 10);
        if (done_cyc.size() > 0) chk("a5_done_cyc", done_cyc[0], 24);
        else chk("a5_done_n", done_cyc.size(), 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
